// File: rtl/bmc_soft.sv
// ---------------------------------------------------------------------------
// bmc_soft: soft-decision branch-metric calculator for a rate-1/2 decoder.
//
// Each received pair is scored against the four possible codewords {x,y}.
// The score is the sum of two per-symbol distances. Symbols are unsigned soft
// values: 0 is a confident 0 and 2^SW-1 is a confident 1. An erased
// (punctured) symbol adds nothing to the score. The block is a two-stage
// valid/ready pipeline with one result per cycle.
//
// Parameters
//   SW    soft bits per symbol (1..8)
//   HARD  1 = use only the symbol MSB, which gives a Hamming metric
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid / in_ready    input handshake
//   rx_pair [2*SW-1:0]     {symbol 1, symbol 0}
//   erase   [1:0]          bit i set = symbol i erased
//   out_valid / out_ready  output handshake
//   bm_00..bm_11 [SW:0]    metric against codeword {sym1,sym0} = xy
//   bm_min_idx [1:0]       xy of the smallest metric (ties go to the lowest xy)
// ---------------------------------------------------------------------------
module bmc_soft #(
   parameter int SW   = 3,
   parameter bit HARD = 1'b0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2*SW-1:0] rx_pair,
   input  logic [1:0]      erase,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [SW:0]     bm_00,
   output logic [SW:0]     bm_01,
   output logic [SW:0]     bm_10,
   output logic [SW:0]     bm_11,
   output logic [1:0]      bm_min_idx
);

   localparam int MW = SW + 1;
   localparam logic [SW-1:0] SMAX = {SW{1'b1}};

   // Stage 0 (combinational): distance of each symbol to bit 0 and to bit 1
   logic [1:0][SW-1:0] dist0_comb;
   logic [1:0][SW-1:0] dist1_comb;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_sym
         logic [SW-1:0] sym;
         logic [SW-1:0] sym_eff;
         assign sym = rx_pair[gi*SW +: SW];
         if (HARD) begin : g_hard
            assign sym_eff = {SW{sym[SW-1]}};
         end else begin : g_soft
            assign sym_eff = sym;
         end
         assign dist0_comb[gi] = sym_eff;
         assign dist1_comb[gi] = SMAX - sym_eff;
      end
   endgenerate

   // Stage 1 registers: raw distances and erase flags. Erasure masking
   // happens in the stage-2 adders.
   logic               s1_valid_reg;
   logic [1:0][SW-1:0] dist0_reg;
   logic [1:0][SW-1:0] dist1_reg;
   logic [1:0]         erase_reg;

   // Stage 2 (combinational): four sums, then the index of the minimum
   logic [3:0][MW-1:0] sum_comb;

   generate
      for (gi = 0; gi < 4; gi++) begin : g_sum
         // gi = {x,y}: x is the expected bit of symbol 1, y that of symbol 0
         logic [SW-1:0] d_sym1;
         logic [SW-1:0] d_sym0;
         if (gi[1]) begin : g_x1
            assign d_sym1 = erase_reg[1] ? '0 : dist1_reg[1];
         end else begin : g_x0
            assign d_sym1 = erase_reg[1] ? '0 : dist0_reg[1];
         end
         if (gi[0]) begin : g_y1
            assign d_sym0 = erase_reg[0] ? '0 : dist1_reg[0];
         end else begin : g_y0
            assign d_sym0 = erase_reg[0] ? '0 : dist0_reg[0];
         end
         assign sum_comb[gi] = {1'b0, d_sym1} + {1'b0, d_sym0};
      end
   endgenerate

   logic [1:0]    min_idx_comb;
   logic [MW-1:0] min_val_comb;

   // Strict less-than while scanning upward keeps the lowest index on ties
   always_comb begin
      min_idx_comb = 2'd0;
      min_val_comb = sum_comb[0];
      for (int i = 1; i < 4; i++) begin
         if (sum_comb[i] < min_val_comb) begin
            min_val_comb = sum_comb[i];
            min_idx_comb = 2'(i);
         end
      end
   end

   // Handshake control
   logic               s2_valid_reg;
   logic [3:0][MW-1:0] bm_reg;
   logic [1:0]         min_idx_reg;
   logic               s1_load;
   logic               s2_load;

   assign s2_load  = s1_valid_reg && (!s2_valid_reg || out_ready);
   // Stage 1 can take a new pair when it is empty or is draining this cycle
   assign in_ready = !s1_valid_reg || !s2_valid_reg || out_ready;
   assign s1_load  = in_valid && in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_reg <= 1'b0;
         dist0_reg    <= '0;
         dist1_reg    <= '0;
         erase_reg    <= '0;
         s2_valid_reg <= 1'b0;
         bm_reg       <= '0;
         min_idx_reg  <= '0;
      end else begin
         if (s1_load) begin
            s1_valid_reg <= 1'b1;
            dist0_reg    <= dist0_comb;
            dist1_reg    <= dist1_comb;
            erase_reg    <= erase;
         end else if (s2_load) begin
            s1_valid_reg <= 1'b0;
         end

         if (s2_load) begin
            s2_valid_reg <= 1'b1;
            bm_reg       <= sum_comb;
            min_idx_reg  <= min_idx_comb;
         end else if (out_ready) begin
            s2_valid_reg <= 1'b0;
         end
      end
   end

   assign out_valid  = s2_valid_reg;
   assign bm_00      = bm_reg[0];
   assign bm_01      = bm_reg[1];
   assign bm_10      = bm_reg[2];
   assign bm_11      = bm_reg[3];
   assign bm_min_idx = min_idx_reg;

endmodule

// File: tb/tb_bmc_soft.sv
// ---------------------------------------------------------------------------
// Testbench for bmc_soft. Two instances (soft and hard-decision, SW=3) share
// the same stimulus. Expected metrics are pushed to a queue when a pair is
// accepted, and popped and compared when a result is drained.
// ---------------------------------------------------------------------------
module tb_bmc_soft;

   localparam int SW = 3;
   localparam int SMAX = 7;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic [5:0] rx_pair;
   logic [1:0] erase;
   logic       out_ready;

   logic       ir_s, ov_s, ir_h, ov_h;
   logic [3:0] s00, s01, s10, s11, h00, h01, h10, h11;
   logic [1:0] sidx, hidx;

   int checks = 0;
   int errors = 0;
   bit rand_ready = 1'b0;

   logic [17:0] q_s[$];
   logic [17:0] q_h[$];
   logic [17:0] saved;
   bit          stalled = 1'b0;

   always #5 clk = ~clk;

   bmc_soft #(.SW(SW), .HARD(1'b0)) dut_soft (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_s),
      .rx_pair(rx_pair), .erase(erase), .out_valid(ov_s), .out_ready(out_ready),
      .bm_00(s00), .bm_01(s01), .bm_10(s10), .bm_11(s11), .bm_min_idx(sidx));

   bmc_soft #(.SW(SW), .HARD(1'b1)) dut_hard (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_h),
      .rx_pair(rx_pair), .erase(erase), .out_valid(ov_h), .out_ready(out_ready),
      .bm_00(h00), .bm_01(h01), .bm_10(h10), .bm_11(h11), .bm_min_idx(hidx));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: {bm_00, bm_01, bm_10, bm_11, min_idx}
   function automatic logic [17:0] model(input logic [5:0] rx, input logic [1:0] er, input bit hard);
      int r [2];
      int bm [4];
      int best;
      logic [3:0] b [4];
      logic [1:0] bi;
      r[0] = int'(rx[2:0]);
      r[1] = int'(rx[5:3]);
      for (int s = 0; s < 2; s++)
         if (hard) r[s] = (r[s] >= 4) ? SMAX : 0;
      for (int k = 0; k < 4; k++) begin
         int x, y, d1, d0;
         x  = k / 2;
         y  = k % 2;
         d1 = er[1] ? 0 : (x == 1 ? SMAX - r[1] : r[1]);
         d0 = er[0] ? 0 : (y == 1 ? SMAX - r[0] : r[0]);
         bm[k] = d1 + d0;
      end
      best = 0;
      for (int k = 1; k < 4; k++)
         if (bm[k] < bm[best]) best = k;
      for (int k = 0; k < 4; k++) b[k] = 4'(bm[k]);
      bi = 2'(best);
      return {b[0], b[1], b[2], b[3], bi};
   endfunction

   // Scoreboard monitor, sampling on the falling edge
   always @(negedge clk) begin
      if (!rst_n) begin
         q_s.delete();
         q_h.delete();
         stalled = 1'b0;
      end else begin
         if (ov_s && out_ready) begin
            if (q_s.size() == 0) chk("soft_spurious_out", ov_s, 0);
            else chk("soft_result", {s00, s01, s10, s11, sidx}, q_s.pop_front());
         end
         if (ov_h && out_ready) begin
            if (q_h.size() == 0) chk("hard_spurious_out", ov_h, 0);
            else chk("hard_result", {h00, h01, h10, h11, hidx}, q_h.pop_front());
         end
         if (in_valid && ir_s) q_s.push_back(model(rx_pair, erase, 1'b0));
         if (in_valid && ir_h) q_h.push_back(model(rx_pair, erase, 1'b1));
         if (ov_s && !out_ready) begin
            if (stalled) chk("stall_hold", {s00, s01, s10, s11, sidx}, saved);
            saved   = {s00, s01, s10, s11, sidx};
            stalled = 1'b1;
         end else begin
            stalled = 1'b0;
         end
      end
   end

   // Present a pair and wait (bounded) until it is accepted
   task automatic send(input logic [5:0] rx, input logic [1:0] er);
      logic acc;
      int   n;
      n        = 0;
      in_valid = 1'b1;
      rx_pair  = rx;
      erase    = er;
      do begin
         if (rand_ready) out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         acc = ir_s;
         @(posedge clk);
         #1;
         n++;
      end while (!acc && n < 50);
      chk("send_accept", acc, 1);
   endtask

   task automatic drain();
      int n;
      n         = 0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      while ((q_s.size() != 0 || q_h.size() != 0 || ov_s) && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain_empty", q_s.size() + q_h.size(), 0);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      rx_pair   = '0;
      erase     = '0;
      out_ready = 1'b0;

      // Reset state
      #2;
      chk("rst_out_valid", ov_s, 0);
      chk("rst_in_ready", ir_s, 1);
      chk("rst_bm_00", s00, 0);
      chk("rst_bm_11", s11, 0);
      chk("rst_min_idx", sidx, 0);
      chk("rst_hard_out_valid", ov_h, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Latency: accepted at the first edge, out_valid after the second
      out_ready = 1'b1;
      send({3'd7, 3'd0}, 2'b00);
      in_valid = 1'b0;
      chk("latency_cycle1", ov_s, 0);
      @(posedge clk);
      #1;
      chk("latency_cycle2", ov_s, 1);
      drain();

      // Directed metric patterns, back to back
      send({3'd3, 3'd4}, 2'b00);
      send({3'd5, 3'd2}, 2'b00);
      send({3'd7, 3'd7}, 2'b10);
      send({3'd3, 3'd3}, 2'b00);
      send({3'd6, 3'd1}, 2'b11);   // all metrics zero: tie to index 0
      send({3'd0, 3'd7}, 2'b01);
      drain();

      // Backpressure: in_ready falls after two accepts while stalled
      out_ready = 1'b0;
      send({3'd1, 3'd2}, 2'b00);
      send({3'd4, 3'd6}, 2'b00);
      in_valid = 1'b1;
      rx_pair  = {3'd7, 3'd3};
      erase    = 2'b00;
      chk("bp_in_ready_low", ir_s, 0);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         chk("bp_in_ready_held", ir_s, 0);
         chk("bp_out_valid_held", ov_s, 1);
      end
      out_ready = 1'b1;
      send({3'd7, 3'd3}, 2'b00);
      send({3'd2, 3'd5}, 2'b01);
      send({3'd0, 3'd0}, 2'b00);
      drain();

      // Mid-stream reset with two pairs in flight
      send({3'd7, 3'd1}, 2'b00);
      send({3'd2, 3'd6}, 2'b00);
      in_valid = 1'b0;
      chk("mid_out_valid_before", ov_s, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_out_valid_dropped", ov_s, 0);
      chk("mid_hard_out_valid", ov_h, 0);
      chk("mid_in_ready", ir_s, 1);
      chk("mid_bm_00_cleared", s00, 0);
      #4;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         chk("mid_no_stale_out", ov_s, 0);
      end

      // Random stream with random downstream stalls
      rand_ready = 1'b1;
      for (int i = 0; i < 24; i++)
         send(6'($urandom), 2'($urandom_range(0, 3)));
      rand_ready = 1'b0;
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
